// File: rtl/vga_capture_if.sv
// Pixel-stream inputs, control and frame-buffer write port of vga_capture.
// master drives raster and control; slave is the capture block.
interface vga_capture_if;
    logic        p_tick;
    logic        vga_hs_n;
    logic        vga_vs_n;
    logic [11:0] vga_rgb;
    logic        start;
    logic        cont;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    modport master (
        output p_tick, vga_hs_n, vga_vs_n, vga_rgb, start, cont,
        input  wr_en, wr_addr, wr_data, busy, frame_done, frame_err
    );

    modport slave (
        input  p_tick, vga_hs_n, vga_vs_n, vga_rgb, start, cont,
        output wr_en, wr_addr, wr_data, busy, frame_done, frame_err
    );
endinterface

// File: rtl/vga_capture.sv
// Captures one 2:1-decimated VGA frame into a frame buffer; VGA_CAPTURE_KEY_EN skips KEY_COLOR pixels.
// Latency: write strobe one clk after the sampling p_tick, frame_done one clk after the last write.
// No backpressure: the buffer must accept a write on every clk that wr_en is high.
module vga_capture #(
    parameter int          H_BP      = 48,
    parameter int          H_ACT     = 640,
    parameter int          V_BP      = 33,
    parameter int          V_ACT     = 480,
    parameter int          BUF_W     = 320,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic          clk,
    input  logic          reset_n,
    vga_capture_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

`ifdef VGA_CAPTURE_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    localparam logic [15:0] L_X_LO   = 16'(H_BP);
    localparam logic [15:0] L_X_HI   = 16'(H_BP + H_ACT);
    localparam logic [15:0] L_Y_LO   = 16'(V_BP);
    localparam logic [15:0] L_Y_HI   = 16'(V_BP + V_ACT);
    localparam logic [15:0] L_X_LAST = 16'(H_ACT - 2);
    localparam logic [15:0] L_Y_LAST = 16'(V_ACT - 2);
    localparam logic [16:0] L_BUF_W  = 17'(BUF_W);

    logic [1:0]  r_state;
    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [15:0] r_tick;
    logic [15:0] r_line;
    logic        r_line_vld;
    logic        r_wr_en;
    logic [16:0] r_wr_addr;
    logic [11:0] r_wr_data;
    logic        r_done_pend;
    logic        r_frame_done;
    logic        r_frame_err;

    logic        w_hs_edge;
    logic        w_vs_edge;
    logic [15:0] w_tick_inc;
    logic [15:0] w_tick_cur;
    logic [15:0] w_line_inc;
    logic [15:0] w_line_cur;
    logic        w_line_ok;
    logic        w_in_cap;
    logic [15:0] w_x;
    logic [15:0] w_y;
    logic        w_x_act;
    logic        w_y_act;
    logic        w_decim;
    logic        w_last;
    logic        w_key_drop;
    logic        w_pix_wr;
    logic [16:0] w_addr;

    assign w_hs_edge  = bus.p_tick & ~r_hs_prev & bus.vga_hs_n;
    assign w_vs_edge  = bus.p_tick & ~r_vs_prev & bus.vga_vs_n;

    // Counters saturate so an absent sync never wraps back into the active window.
    assign w_tick_inc = (&r_tick) ? r_tick : r_tick + 16'd1;
    assign w_tick_cur = w_hs_edge ? 16'd0 : w_tick_inc;
    assign w_line_inc = (&r_line) ? r_line : r_line + 16'd1;
    assign w_line_cur = w_hs_edge ? (r_line_vld ? w_line_inc : 16'd0) : r_line;
    assign w_line_ok  = r_line_vld | w_hs_edge;

    // A vsync edge in CAPTURE restarts the frame, so its own tick never produces a pixel.
    assign w_in_cap   = (r_state == S_CAPTURE) & bus.p_tick & ~w_vs_edge
                        & ~r_done_pend & w_line_ok;

    assign w_x        = w_tick_cur - L_X_LO;
    assign w_y        = w_line_cur - L_Y_LO;
    assign w_x_act    = (w_tick_cur >= L_X_LO) && (w_tick_cur < L_X_HI);
    assign w_y_act    = (w_line_cur >= L_Y_LO) && (w_line_cur < L_Y_HI);
    assign w_decim    = w_in_cap & w_x_act & w_y_act & ~w_x[0] & ~w_y[0];
    assign w_last     = w_decim & (w_x == L_X_LAST) & (w_y == L_Y_LAST);

    // The last pixel ends the frame even when it is keyed out.
    assign w_key_drop = KEY_EN & (bus.vga_rgb == KEY_COLOR);
    assign w_pix_wr   = w_decim & ~w_key_drop;
    assign w_addr     = 17'(w_y[15:1]) * L_BUF_W + 17'(w_x[15:1]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_hs_prev    <= 1'b1;
            r_vs_prev    <= 1'b1;
            r_tick       <= 16'd0;
            r_line       <= 16'd0;
            r_line_vld   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 17'd0;
            r_wr_data    <= 12'd0;
            r_done_pend  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_wr_en      <= w_pix_wr;
            r_done_pend  <= w_last;
            r_frame_done <= 1'b0;

            if (w_pix_wr) begin
                r_wr_addr <= w_addr;
                r_wr_data <= bus.vga_rgb;
            end

            if (bus.p_tick) begin
                r_hs_prev <= bus.vga_hs_n;
                r_vs_prev <= bus.vga_vs_n;
                r_tick    <= w_tick_cur;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_ARMED;
                        r_frame_err <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_vs_edge) begin
                        r_state    <= S_CAPTURE;
                        r_line     <= 16'd0;
                        r_line_vld <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (r_done_pend) begin
                        r_frame_done <= 1'b1;
                        r_state      <= bus.cont ? S_ARMED : S_IDLE;
                    end else if (w_vs_edge) begin
                        r_frame_err <= 1'b1;
                        r_line      <= 16'd0;
                        r_line_vld  <= 1'b0;
                    end else if (w_hs_edge) begin
                        r_line     <= w_line_cur;
                        r_line_vld <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboarded bench for vga_capture on a shrunken raster with randomized p_tick spacing and colours.
module tb_vga_capture;

    localparam int H_BP  = 4;
    localparam int H_ACT = 16;
    localparam int V_BP  = 3;
    localparam int V_ACT = 12;
    localparam int BUF_W = 10;
    localparam int LT    = H_BP + H_ACT + 6;
    localparam int NL    = V_BP + V_ACT + 4;
    localparam logic [11:0] KEY = 12'h0F0;
`ifdef VGA_CAPTURE_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    typedef enum int {M_IDLE, M_ARMED, M_CAP} mstate_t;
    typedef struct {
        bit          done;
        logic [16:0] addr;
        logic [11:0] data;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_capture_if bus();

    vga_capture #(
        .H_BP(H_BP), .H_ACT(H_ACT), .V_BP(V_BP), .V_ACT(V_ACT),
        .BUF_W(BUF_W), .KEY_COLOR(KEY)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    exp_t    q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      exp_wr = 0, exp_done = 0, seen_wr = 0, seen_done = 0;
    mstate_t m_state = M_IDLE;
    bit      m_err   = 1'b0;
    bit      m_cont  = 1'b0;
    int      m_line  = -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every write or frame_done the DUT presents consumes the next expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1) begin
            if (bus.wr_en === 1'b1) begin
                seen_wr++;
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL wr_unexpected: write addr %0d data %0h, expected nothing", bus.wr_addr, bus.wr_data);
                end else begin
                    e = q.pop_front();
                    check("wr_slot_is_write", {31'd0, e.done}, 32'd0);
                    check("wr_addr", {15'd0, bus.wr_addr}, {15'd0, e.addr});
                    check("wr_data", {20'd0, bus.wr_data}, {20'd0, e.data});
                end
            end
            if (bus.frame_done === 1'b1) begin
                seen_done++;
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL done_unexpected: frame_done 1, expected no pulse");
                end else begin
                    e = q.pop_front();
                    check("done_slot_is_done", {31'd0, e.done}, 32'd1);
                end
            end
        end
    end

    function automatic logic [11:0] color(input int mode, input int salt, input int l, input int p);
        int x, y, h;
        x = p - 2 - H_BP;
        y = l - 2 - V_BP;
        h = (l * 131 + p * 29 + salt) ^ (salt >>> 9);
        case (mode)
            1:       return 12'(h);
            2:       return (x < 8) ? KEY : {4'(x), 4'(y), 4'h0};
            default: return {4'(x), 4'(y), 4'h0};
        endcase
    endfunction

    // Reference model, one raster line at a time: vsync rises at line 2 tick 0, hsync at tick 2.
    task automatic model_line(input int l, input int mode, input int salt, input bit st_vs);
        int         y;
        logic [11:0] c;
        exp_t       e;
        if (l == 2) begin
            if (m_state == M_ARMED) begin
                m_state = M_CAP; m_line = -1;
            end else if (m_state == M_CAP) begin
                m_err = 1'b1; m_line = -1;
            end
        end
        if (st_vs && m_state == M_IDLE) begin
            m_state = M_ARMED; m_err = 1'b0;
        end
        if (m_state == M_CAP) begin
            m_line++;
            y = m_line - V_BP;
            if (y >= 0 && y < V_ACT && (y % 2) == 0) begin
                for (int x = 0; x < H_ACT; x += 2) begin
                    c = color(mode, salt, l, x + H_BP + 2);
                    if (!(KEY_EN && c == KEY)) begin
                        e.done = 1'b0;
                        e.addr = 17'((y / 2) * BUF_W + x / 2);
                        e.data = c;
                        q.push_back(e);
                        exp_wr++;
                    end
                end
                if (y == V_ACT - 2) begin
                    e.done = 1'b1; e.addr = '0; e.data = '0;
                    q.push_back(e);
                    exp_done++;
                    m_state = m_cont ? M_ARMED : M_IDLE;
                end
            end
        end
    endtask

    // One p_tick followed by 0-2 idle clks carrying garbage on the sampled inputs.
    task automatic tick(input logic hs, input logic vs, input logic [11:0] rgb, input bit st);
        bus.p_tick   = 1'b1;
        bus.vga_hs_n = hs;
        bus.vga_vs_n = vs;
        bus.vga_rgb  = rgb;
        bus.start    = st;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.p_tick = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            bus.vga_hs_n = 1'($urandom);
            bus.vga_vs_n = 1'($urandom);
            bus.vga_rgb  = 12'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic line_end();
        bus.p_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("busy", {31'd0, bus.busy}, {31'd0, (m_state != M_IDLE)});
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, m_err});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"},      {31'd0, bus.wr_en},      32'd0);
        check({tag, "_wr_addr"},    {15'd0, bus.wr_addr},    32'd0);
        check({tag, "_wr_data"},    {20'd0, bus.wr_data},    32'd0);
        check({tag, "_busy"},       {31'd0, bus.busy},       32'd0);
        check({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
        check({tag, "_frame_err"},  {31'd0, bus.frame_err},  32'd0);
    endtask

    task automatic do_start();
        bus.p_tick = 1'b0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (m_state == M_IDLE) begin
            m_state = M_ARMED; m_err = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.p_tick = 1'b0;
        reset_n    = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        check("queue_at_reset", q.size(), 32'd0);
        reset_n = 1'b1;
        m_state = M_IDLE; m_err = 1'b0; m_line = -1;
    endtask

    task automatic run_frame(input int nl, input int mode, input bit st_vs, input int rst_at);
        int salt;
        salt = $urandom_range(0, 65535);
        for (int l = 0; l < nl; l++) begin
            model_line(l, mode, salt, st_vs && l == 2);
            for (int p = 0; p < LT; p++)
                tick(p >= 2, l >= 2, color(mode, salt, l, p), st_vs && l == 2 && p == 0);
            line_end();
            if (l == rst_at) do_reset();
        end
    endtask

    task automatic set_cont(input bit c);
        m_cont   = c;
        bus.cont = c;
    endtask

    initial begin
        bus.p_tick   = 1'b0;
        bus.vga_hs_n = 1'b1;
        bus.vga_vs_n = 1'b1;
        bus.vga_rgb  = 12'd0;
        bus.start    = 1'b0;
        bus.cont     = 1'b0;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        set_cont(1'b0);
        do_start();
        run_frame(NL, 0, 1'b0, -1);          // single frame, pattern colours
        run_frame(NL, 1, 1'b0, -1);          // not armed: no writes

        set_cont(1'b1);
        do_start();
        run_frame(NL, 1, 1'b0, -1);          // three back-to-back frames
        do_start();                          // ignored: already armed
        run_frame(NL, 2, 1'b0, -1);
        run_frame(NL, 0, 1'b0, -1);

        run_frame(2 + V_BP + 6, 1, 1'b0, -1); // truncated by an early vsync
        set_cont(1'b0);
        run_frame(NL, 0, 1'b0, -1);          // restarted frame completes, error sticks
        do_start();                          // clears frame_err
        run_frame(NL, 1, 1'b0, -1);

        do_start();
        run_frame(NL, 0, 1'b0, 2 + V_BP + 4); // reset mid-frame
        run_frame(NL, 0, 1'b0, -1);          // idle after reset

        run_frame(NL, 1, 1'b1, -1);          // start on the vsync edge: not captured
        run_frame(NL, 1, 1'b0, -1);          // captured

        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        check("write_count", seen_wr, exp_wr);
        check("done_count", seen_done, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
